// File: rtl/data_memory_controller_if.sv
// Per-core data-memory bus: flattened request slices from the cores and
// read data / acknowledge returned by the shared memory controller.
interface data_memory_controller_if #(
   parameter int reg_width  = 12,
   parameter int addr_width = 12,
   parameter int core_count = 2
);
   logic [core_count-1:0]            mem_req;
   logic [core_count-1:0]            mem_write;
   logic [addr_width*core_count-1:0] address;
   logic [reg_width*core_count-1:0]  datain;
   logic [reg_width*core_count-1:0]  dataout;
   logic [core_count-1:0]            mem_ack;

   modport master (
      output mem_req, mem_write, address, datain,
      input  dataout, mem_ack
   );

   modport slave (
      input  mem_req, mem_write, address, datain,
      output dataout, mem_ack
   );
endinterface

// File: rtl/data_memory_controller.sv
// Shared single-port data memory serving core_count requesters round-robin;
// each access takes IDLE -> ACCESS -> ACK and ends with a one-cycle mem_ack.
module data_memory_controller #(
   parameter int reg_width     = 12,
   parameter int addr_width    = 12,
   parameter int core_count    = 2,
   parameter int data_mem_size = 4096
) (
   input logic clk,
   input logic reset,
   data_memory_controller_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

   localparam int ptr_w = (core_count > 1) ? $clog2(core_count) : 1;
   localparam int idx_w = (data_mem_size > 1) ? $clog2(data_mem_size) : 1;
   localparam logic [addr_width:0] mem_words = (addr_width+1)'(data_mem_size);
   localparam logic [ptr_w-1:0]    last_init = ptr_w'(core_count - 1);

   state_t state, state_next;

   logic [ptr_w-1:0]      last, lat_core, grant;
   logic                  grant_valid;
   logic [addr_width-1:0] sel_addr, lat_addr;
   logic [reg_width-1:0]  sel_data, lat_data;
   logic                  sel_write, lat_write;
   logic                  in_range, ram_we, ram_re;
   logic [core_count-1:0] ack;

   logic [reg_width-1:0]            mem [data_mem_size];
   logic [reg_width*core_count-1:0] dataout_q;

   // Round-robin: first requester above `last`, then wrap to cores 0..last.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      grant_valid = 1'b0;
      grant       = '0;
      for (int i = 0; i < core_count; i++) begin
         if (!grant_valid && (i > int'(last)) && bus.mem_req[i]) begin
            grant_valid = 1'b1;
            grant       = ptr_w'(i);
         end
      end
      for (int i = 0; i < core_count; i++) begin
         if (!grant_valid && (i <= int'(last)) && bus.mem_req[i]) begin
            grant_valid = 1'b1;
            grant       = ptr_w'(i);
         end
      end
   end

   always_comb begin
      sel_addr  = '0;
      sel_data  = '0;
      sel_write = 1'b0;
      for (int i = 0; i < core_count; i++) begin
         if (grant == ptr_w'(i)) begin
            sel_addr  = bus.address[i*addr_width +: addr_width];
            sel_data  = bus.datain[i*reg_width +: reg_width];
            sel_write = bus.mem_write[i];
         end
      end
   end

   // State register plus the request latched at the IDLE sample.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state     <= IDLE;
         last      <= last_init;
         lat_core  <= '0;
         lat_addr  <= '0;
         lat_data  <= '0;
         lat_write <= 1'b0;
      end else begin
         state <= state_next;
         if (state == IDLE && grant_valid) begin
            lat_core  <= grant;
            lat_addr  <= sel_addr;
            lat_data  <= sel_data;
            lat_write <= sel_write;
         end
         if (state == ACCESS) last <= lat_core;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant_valid) state_next = ACCESS;
         ACCESS:  state_next = ACK;
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign in_range = ({1'b0, lat_addr} < mem_words);

   // Outputs decode only the state register and the latched winner.
   always_comb begin
      ack    = '0;
      ram_we = 1'b0;
      ram_re = 1'b0;
      case (state)
         ACCESS: begin
            ram_we = lat_write && in_range;
            ram_re = !lat_write;
         end
         ACK: begin
            for (int i = 0; i < core_count; i++) begin
               if (lat_core == ptr_w'(i)) ack[i] = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // NOTE: the array is deliberately left out of reset so it maps onto a plain RAM macro.
   always_ff @(posedge clk) begin
      if (ram_we) mem[lat_addr[idx_w-1:0]] <= lat_data;
   end

   // Synchronous read lands directly in the winner's dataout slice.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dataout_q <= '0;
      end else if (ram_re) begin
         for (int i = 0; i < core_count; i++) begin
            if (lat_core == ptr_w'(i)) begin
               dataout_q[i*reg_width +: reg_width] <= in_range ? mem[lat_addr[idx_w-1:0]] : '0;
            end
         end
      end
   end

   assign bus.dataout = dataout_q;
   assign bus.mem_ack = ack;

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed bench for data_memory_controller: a full-size and a 16-word
// instance share the same stimulus; each scenario checks its own results.
module tb_data_memory_controller;

   localparam int rw = 12;
   localparam int aw = 12;
   localparam int cc = 2;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [cc-1:0]    req  = '0;
   logic [cc-1:0]    wr   = '0;
   logic [aw*cc-1:0] addr = '0;
   logic [rw*cc-1:0] din  = '0;

   data_memory_controller_if #(.reg_width(rw), .addr_width(aw), .core_count(cc)) bus_full ();
   data_memory_controller_if #(.reg_width(rw), .addr_width(aw), .core_count(cc)) bus_small ();

   assign bus_full.mem_req    = req;
   assign bus_full.mem_write  = wr;
   assign bus_full.address    = addr;
   assign bus_full.datain     = din;
   assign bus_small.mem_req   = req;
   assign bus_small.mem_write = wr;
   assign bus_small.address   = addr;
   assign bus_small.datain    = din;

   data_memory_controller #(
      .reg_width(rw), .addr_width(aw), .core_count(cc), .data_mem_size(4096)
   ) dut_full (
      .clk(clk), .reset(reset), .bus(bus_full.slave)
   );

   data_memory_controller #(
      .reg_width(rw), .addr_width(aw), .core_count(cc), .data_mem_size(16)
   ) dut_small (
      .clk(clk), .reset(reset), .bus(bus_small.slave)
   );

   int n_compared   = 0;
   int n_mismatched = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int core, input logic w, input logic [aw-1:0] a, input logic [rw-1:0] d);
      req[core]              = 1'b1;
      wr[core]               = w;
      addr[core*aw +: aw]    = a;
      din[core*rw +: rw]     = d;
   endtask

   task automatic release_req(input int core);
      req[core] = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_compared++;
      if (bus_full.mem_ack !== 2'b00) begin
         n_mismatched++; $display("FAIL rst_ack_full: got %b want 00", bus_full.mem_ack);
      end
      n_compared++;
      if (bus_full.dataout !== 24'h000000) begin
         n_mismatched++; $display("FAIL rst_dout_full: got %h want 000000", bus_full.dataout);
      end
      n_compared++;
      if (bus_small.dataout !== 24'h000000) begin
         n_mismatched++; $display("FAIL rst_dout_small: got %h want 000000", bus_small.dataout);
      end
      #10 reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_compared++;
         if (bus_full.mem_ack !== 2'b00 || bus_small.mem_ack !== 2'b00) begin
            n_mismatched++;
            $display("FAIL idle_no_req_ack[%0d]: got %b/%b want 00/00", k, bus_full.mem_ack, bus_small.mem_ack);
         end
      end
   endtask

   task automatic test_write_read_core0();
      drive(0, 1'b1, 12'h005, 12'hABC);
      tick();
      n_compared++;
      if (bus_full.mem_ack !== 2'b00) begin
         n_mismatched++; $display("FAIL wr0_access_ack: got %b want 00", bus_full.mem_ack);
      end
      tick();
      n_compared++;
      if (bus_full.mem_ack !== 2'b01) begin
         n_mismatched++; $display("FAIL wr0_ack: got %b want 01", bus_full.mem_ack);
      end
      n_compared++;
      if (bus_full.dataout !== 24'h000000) begin
         n_mismatched++; $display("FAIL wr0_dout_untouched: got %h want 000000", bus_full.dataout);
      end
      release_req(0);
      tick();
      n_compared++;
      if (bus_full.mem_ack !== 2'b00) begin
         n_mismatched++; $display("FAIL wr0_ack_one_cycle: got %b want 00", bus_full.mem_ack);
      end
      drive(0, 1'b0, 12'h005, 12'h000);
      tick();
      tick();
      n_compared++;
      if (bus_full.mem_ack !== 2'b01) begin
         n_mismatched++; $display("FAIL rd0_ack: got %b want 01", bus_full.mem_ack);
      end
      n_compared++;
      if (bus_full.dataout[11:0] !== 12'hABC) begin
         n_mismatched++; $display("FAIL rd0_dout_lo: got %h want abc", bus_full.dataout[11:0]);
      end
      n_compared++;
      if (bus_full.dataout[23:12] !== 12'h000) begin
         n_mismatched++; $display("FAIL rd0_dout_hi: got %h want 000", bus_full.dataout[23:12]);
      end
      release_req(0);
      tick();
   endtask

   task automatic test_contention();
      logic [1:0] exp_ack [13];
      exp_ack = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00,
                  2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
      reset = 1'b0;
      #2 reset = 1'b1;
      n_compared++;
      if (bus_full.dataout !== 24'h000000) begin
         n_mismatched++; $display("FAIL cont_reset_dout: got %h want 000000", bus_full.dataout);
      end
      drive(0, 1'b0, 12'h005, 12'h000);
      drive(1, 1'b1, 12'h00A, 12'h0AA);
      for (int k = 0; k < 13; k++) begin
         tick();
         n_compared++;
         if (bus_full.mem_ack !== exp_ack[k]) begin
            n_mismatched++; $display("FAIL cont_ack[%0d]: got %b want %b", k, bus_full.mem_ack, exp_ack[k]);
         end
         if (k == 1) begin
            n_compared++;
            if (bus_full.dataout[11:0] !== 12'hABC) begin
               n_mismatched++; $display("FAIL cont_rd0_dout: got %h want abc", bus_full.dataout[11:0]);
            end
         end
         if (k == 4) begin
            n_compared++;
            if (bus_full.dataout[23:12] !== 12'h000) begin
               n_mismatched++; $display("FAIL cont_wr1_dout_hi: got %h want 000", bus_full.dataout[23:12]);
            end
         end
         if (k == 10) begin
            release_req(0);
            release_req(1);
         end
      end
   endtask

   task automatic test_cross_core();
      drive(1, 1'b1, 12'h0FF, 12'h3C3);
      tick();
      tick();
      n_compared++;
      if (bus_full.mem_ack !== 2'b10) begin
         n_mismatched++; $display("FAIL xc_wr1_ack: got %b want 10", bus_full.mem_ack);
      end
      release_req(1);
      tick();
      drive(0, 1'b0, 12'h0FF, 12'h000);
      tick();
      tick();
      n_compared++;
      if (bus_full.mem_ack !== 2'b01 || bus_full.dataout[11:0] !== 12'h3C3) begin
         n_mismatched++;
         $display("FAIL xc_rd0: got ack %b data %h want ack 01 data 3c3", bus_full.mem_ack, bus_full.dataout[11:0]);
      end
      release_req(0);
      tick();
      drive(1, 1'b0, 12'h00A, 12'h000);
      tick();
      tick();
      n_compared++;
      if (bus_full.mem_ack !== 2'b10 || bus_full.dataout[23:12] !== 12'h0AA) begin
         n_mismatched++;
         $display("FAIL xc_rd1_contended_wr: got ack %b data %h want ack 10 data 0aa", bus_full.mem_ack, bus_full.dataout[23:12]);
      end
      release_req(1);
      tick();
   endtask

   task automatic test_out_of_range();
      drive(0, 1'b1, 12'h000, 12'h5A5);
      tick();
      tick();
      release_req(0);
      tick();
      drive(0, 1'b1, 12'h020, 12'h777);
      tick();
      tick();
      n_compared++;
      if (bus_small.mem_ack !== 2'b01) begin
         n_mismatched++; $display("FAIL oor_wr_ack: got %b want 01", bus_small.mem_ack);
      end
      release_req(0);
      tick();
      drive(0, 1'b0, 12'h020, 12'h000);
      tick();
      tick();
      n_compared++;
      if (bus_small.mem_ack !== 2'b01 || bus_small.dataout[11:0] !== 12'h000) begin
         n_mismatched++;
         $display("FAIL oor_rd: got ack %b data %h want ack 01 data 000", bus_small.mem_ack, bus_small.dataout[11:0]);
      end
      release_req(0);
      tick();
      drive(0, 1'b0, 12'h000, 12'h000);
      tick();
      tick();
      n_compared++;
      if (bus_small.dataout[11:0] !== 12'h5A5) begin
         n_mismatched++; $display("FAIL oor_no_alias: got %h want 5a5", bus_small.dataout[11:0]);
      end
      release_req(0);
      tick();
   endtask

   task automatic test_reset_mid_run();
      drive(0, 1'b0, 12'h005, 12'h000);
      drive(1, 1'b0, 12'h005, 12'h000);
      tick();
      tick();
      n_compared++;
      if (bus_full.mem_ack !== 2'b10 || bus_full.dataout !== 24'hABC5A5) begin
         n_mismatched++;
         $display("FAIL rr_pick_core1: got ack %b data %h want ack 10 data abc5a5", bus_full.mem_ack, bus_full.dataout);
      end
      #2 reset = 1'b0;
      #1;
      n_compared++;
      if (bus_full.mem_ack !== 2'b00 || bus_small.mem_ack !== 2'b00) begin
         n_mismatched++;
         $display("FAIL midrst_ack: got %b/%b want 00/00", bus_full.mem_ack, bus_small.mem_ack);
      end
      n_compared++;
      if (bus_full.dataout !== 24'h000000 || bus_small.dataout !== 24'h000000) begin
         n_mismatched++;
         $display("FAIL midrst_dout: got %h/%h want 000000/000000", bus_full.dataout, bus_small.dataout);
      end
      release_req(0);
      release_req(1);
      #2 reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_compared++;
         if (bus_full.mem_ack !== 2'b00) begin
            n_mismatched++; $display("FAIL midrst_idle[%0d]: got %b want 00", k, bus_full.mem_ack);
         end
      end
   endtask

   task automatic test_reset_during_access();
      drive(1, 1'b1, 12'h010, 12'h222);
      tick();
      tick();
      n_compared++;
      if (bus_full.mem_ack !== 2'b10) begin
         n_mismatched++; $display("FAIL preset_ack: got %b want 10", bus_full.mem_ack);
      end
      release_req(1);
      tick();
      drive(1, 1'b1, 12'h010, 12'h111);
      tick();
      #2 reset = 1'b0;
      release_req(1);
      for (int k = 0; k < 2; k++) begin
         tick();
         n_compared++;
         if (bus_full.mem_ack !== 2'b00) begin
            n_mismatched++; $display("FAIL abort_no_ack[%0d]: got %b want 00", k, bus_full.mem_ack);
         end
         if (k == 0) #2 reset = 1'b1;
      end
      drive(1, 1'b0, 12'h010, 12'h000);
      tick();
      tick();
      n_compared++;
      if (bus_full.mem_ack !== 2'b10 || bus_full.dataout[23:12] !== 12'h222) begin
         n_mismatched++;
         $display("FAIL abort_not_committed: got ack %b data %h want ack 10 data 222", bus_full.mem_ack, bus_full.dataout[23:12]);
      end
      release_req(1);
      tick();
   endtask

   initial begin
      test_reset();
      test_write_read_core0();
      test_contention();
      test_cross_core();
      test_out_of_range();
      test_reset_mid_run();
      test_reset_during_access();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
